muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide unit. It is the sequential companion to the single-cycle ALU and its ALU-control decode. It executes the eight M-extension ops selected by funct3 over multiple cycles and uses a start/busy/done handshake, so the core can stall on M instructions. XLEN is parametrised for reuse in narrow test configurations, and an optional fast path resolves special cases early.

---
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq: iterative RV32M multiply/divide unit.
//
// Runs the eight M-extension ops selected by funct3 in radix-2 steps, one per
// clock. An accepted start moves IDLE -> CALC (XLEN steps) -> FIX (sign
// correction, result load) -> DONE (one-cycle done pulse) -> IDLE.
// With FAST_SPECIAL=1, divide-by-zero and signed overflow go
// IDLE -> CALC -> DONE, skipping the iterations and FIX.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   request, accepted only while idle
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,  111 REMU
//   rs1_val in   operand A (multiplicand / dividend)
//   rs2_val in   operand B (multiplier / divisor)
//   busy    out  op in flight (CALC or FIX)
//   done    out  one-cycle pulse, result valid
//   result  out  op result, held until the next result load
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   result_r;

    // operation context captured at acceptance
    logic [2:0]        op;
    logic              a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0]   a_orig;
    logic [XLEN-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
    logic [XLEN-1:0]   hi, lo;   // product halves, or remainder / quotient

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic a_is_signed(input logic [2:0] f);
        return f[2] ? ~f[0] : (f[1:0] != 2'b11);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM
    function automatic logic b_is_signed(input logic [2:0] f);
        return f[2] ? ~f[0] : ~f[1];
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // RISC-V mandated results for divide-by-zero and signed overflow
    function automatic logic [XLEN-1:0] special_result(
        input logic [2:0] f, input logic bz, input logic [XLEN-1:0] a);
        if (bz) return f[1] ? a : ALL_ONES;
        else    return f[1] ? '0 : a;
    endfunction

    function automatic logic [XLEN-1:0] fix_result(
        input logic [2:0] f, input logic an, input logic bn, input logic bz,
        input logic ov, input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] h, input logic [XLEN-1:0] l);
        logic [2*XLEN-1:0] prod;
        if (!f[2]) begin
            prod = (an ^ bn) ? (~{h, l} + 1'b1) : {h, l};
            return (f[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        if (bz || ov) return special_result(f, bz, a);
        // quotient sign follows rs1^rs2, remainder sign follows rs1
        return f[1] ? cond_neg(an, h) : cond_neg(an ^ bn, l);
    endfunction

    logic            accept;
    logic            a_neg_in, b_neg_in, b_zero_in, ovf_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;

    always_comb begin
        accept    = (state == IDLE) && start;
        a_neg_in  = a_is_signed(funct3) && rs1_val[XLEN-1];
        b_neg_in  = b_is_signed(funct3) && rs2_val[XLEN-1];
        a_mag_in  = cond_neg(a_neg_in, rs1_val);
        b_mag_in  = cond_neg(b_neg_in, rs2_val);
        b_zero_in = (rs2_val == '0);
        ovf_in    = funct3[2] && !funct3[0] && (rs1_val == MOST_NEG) && (rs2_val == ALL_ONES);
    end

    // multiply step: conditional add of the multiplicand, then shift right
    logic [XLEN:0] mul_sum;
    // divide step: shift in next dividend bit, trial subtract the divisor
    logic [XLEN:0] div_sh, div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd};
    end

    // control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: cnt <= '0;
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (FAST_SPECIAL && special)
                        result_r <= special_result(op, b_zero, a_orig);
                end
                FIX:  result_r <= fix_result(op, a_neg, b_neg, b_zero, ovf, a_orig, hi, lo);
                default: ;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (accept) begin
            op      <= funct3;
            a_neg   <= a_neg_in;
            b_neg   <= b_neg_in;
            b_zero  <= b_zero_in;
            ovf     <= ovf_in;
            special <= funct3[2] && (b_zero_in || ovf_in);
            a_orig  <= rs1_val;
            hi      <= '0;
            opnd    <= funct3[2] ? b_mag_in : a_mag_in;
            lo      <= funct3[2] ? a_mag_in : b_mag_in;
        end else if (state == CALC) begin
            if (!op[2]) begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
                hi <= div_diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
                hi <= div_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // next state and outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: begin
                busy = 1'b1;
                if (FAST_SPECIAL && special) state_nx = DONE;
                else if (cnt == CNT_LAST)    state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign result = result_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq: directed bench for muldiv_seq.
// Three instances: XLEN=32 fixed latency (u0), XLEN=32 FAST_SPECIAL=1 (u1)
// sharing the same inputs, and XLEN=8 (u8) with its own inputs.
// Edge numbering: sample index k is taken on the falling edge just before
// rising edge n+k, where n is the edge that accepts start.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start8;
    logic [2:0]  funct3, f3_8;
    logic [31:0] rs1, rs2;
    logic [7:0]  a8, b8;
    logic        busy0, done0, busy1, done1, busy8, done8;
    logic [31:0] res0, res1;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1), .rs2_val(rs2), .busy(busy0), .done(done0), .result(res0));

    muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1), .rs2_val(rs2), .busy(busy1), .done(done1), .result(res1));

    muldiv_seq #(.XLEN(8), .FAST_SPECIAL(1'b0)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .funct3(f3_8),
        .rs1_val(a8), .rs2_val(b8), .busy(busy8), .done(done8), .result(res8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op on the 32-bit pair and/or the 8-bit unit, watch 40 edges,
    // then check results, done timing, pulse count and busy window.
    task automatic run_op(
        input string tag,
        input bit go32, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] exp, input int lat1,
        input bit go8, input logic [2:0] f8, input logic [7:0] x8, input logic [7:0] y8,
        input logic [7:0] exp8, input bit poke);
        int d0, d1, d8, p0, p1, p8;
        bit bok0, bok1, bok8;
        d0 = 0; d1 = 0; d8 = 0; p0 = 0; p1 = 0; p8 = 0;
        bok0 = 1; bok1 = 1; bok8 = 1;
        @(negedge clk);
        if (go32) begin start = 1'b1; funct3 = f; rs1 = a; rs2 = b; end
        if (go8)  begin start8 = 1'b1; f3_8 = f8; a8 = x8; b8 = y8; end
        @(posedge clk);
        #1 start = 1'b0; start8 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done0) begin p0++; if (d0 == 0) d0 = k; end
            if (done1) begin p1++; if (d1 == 0) d1 = k; end
            if (done8) begin p8++; if (d8 == 0) d8 = k; end
            if (busy0 !== (k <= 33))   bok0 = 0;
            if (busy1 !== (k < lat1))  bok1 = 0;
            if (busy8 !== (k <= 9))    bok8 = 0;
            if (poke && k == 4) begin start = 1'b1; funct3 = 3'b011; rs1 = 32'd1; rs2 = 32'd1; end
            if (poke && k == 5) start = 1'b0;
        end
        if (go32) begin
            chk({tag, " u0 result"}, res0, exp);
            chk({tag, " u0 done edge"}, d0, 34);
            chk({tag, " u0 done pulses"}, p0, 1);
            chk({tag, " u0 busy window"}, bok0, 1);
            chk({tag, " u1 result"}, res1, exp);
            chk({tag, " u1 done edge"}, d1, lat1);
            chk({tag, " u1 done pulses"}, p1, 1);
            chk({tag, " u1 busy window"}, bok1, 1);
        end
        if (go8) begin
            chk({tag, " u8 result"}, {24'd0, res8}, {24'd0, exp8});
            chk({tag, " u8 done edge"}, d8, 10);
            chk({tag, " u8 done pulses"}, p8, 1);
            chk({tag, " u8 busy window"}, bok8, 1);
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
        funct3 = 3'b000; f3_8 = 3'b000;
        rs1 = '0; rs2 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy0", busy0, 0);
        chk("reset done0", done0, 0);
        chk("reset res0", res0, 0);
        chk("reset res8", {24'd0, res8}, 0);
        rst_n = 1'b1;

        run_op("MUL",    1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34,
                         1, 3'b011, 8'hFF, 8'hFF, 8'hFE, 0);
        run_op("MULH",   1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34,
                         1, 3'b100, 8'h80, 8'hFF, 8'h80, 0);
        run_op("MULHU",  1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34,
                         1, 3'b101, 8'd20, 8'd3, 8'd6, 0);
        run_op("MULHSU", 1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("DIV",    1, 3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("REM",    1, 3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("DIVU",   1, 3'b101, 32'd20, 32'd3, 32'd6, 34,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("REMU",   1, 3'b111, 32'd20, 32'd3, 32'd2, 34,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("DIV0",   1, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 2,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("REMU0",  1, 3'b111, 32'd5, 32'd0, 32'd5, 2,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("DIVOVF", 1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("REMOVF", 1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 0);
        run_op("POKE",   1, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34,
                         0, 3'b000, 8'd0, 8'd0, 8'd0, 1);

        // reset in the middle of an op
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        start8 = 1'b1; f3_8 = 3'b101; a8 = 8'd100; b8 = 8'd7;
        @(posedge clk);
        #1 start = 1'b0; start8 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset busy0", busy0, 0);
        chk("midreset done0", done0, 0);
        chk("midreset res0", res0, 0);
        chk("midreset busy1", busy1, 0);
        chk("midreset res1", res1, 0);
        chk("midreset busy8", busy8, 0);
        chk("midreset res8", {24'd0, res8}, 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0 || done1 || done8) pulses++;
        end
        chk("midreset no done", pulses, 0);

        run_op("AFTERRST", 1, 3'b101, 32'd100, 32'd7, 32'd14, 34,
                           1, 3'b111, 8'd100, 8'd7, 8'd2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
